// File: rtl/pcie_pkg.sv
// ============================================================================
// pcie_pkg : defaults and lane constants shared by the byte recombiner
// Rev 1.0
// ============================================================================
`default_nettype none

package pcie_pkg;

  localparam int unsigned DATA_W_DEFAULT     = 8;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

endpackage

`default_nettype wire

// File: rtl/mux_recombinador_2a1_lane_fifo.sv
// ============================================================================
// lane_fifo : per-lane skew FIFO with sticky overflow on dropped pushes
// Rev 1.0
// ============================================================================
`default_nettype none

module lane_fifo
  import pcie_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              overflow_q, overflow_d;
  logic              w_do_push;
  logic              w_do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign head_data = mem_q[rd_ptr_q];
  assign overflow  = overflow_q;

  // A full FIFO still accepts a push when its head leaves on the same edge.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & full & ~w_do_pop);
    if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/mux_recombinador_2a1.sv
// ============================================================================
// mux_recombinador_2a1 : merges even/odd byte lanes back into one byte stream
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_recombinador_2a1
  import pcie_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              expect_lane,
  output logic              overflow0,
  output logic              overflow1
);

  lane_e             sel_q, sel_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              w_pop0, w_pop1;
  logic              w_empty0, w_empty1;
  logic              w_full0, w_full1;
  logic [DATA_W-1:0] w_head0, w_head1;
  logic              w_unused_full;

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_lane0 (
    .clk       (clk),
    .reset     (reset),
    .push      (valid_in0),
    .push_data (data_in0),
    .pop       (w_pop0),
    .head_data (w_head0),
    .empty     (w_empty0),
    .full      (w_full0),
    .overflow  (overflow0)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_lane1 (
    .clk       (clk),
    .reset     (reset),
    .push      (valid_in1),
    .push_data (data_in1),
    .pop       (w_pop1),
    .head_data (w_head1),
    .empty     (w_empty1),
    .full      (w_full1),
    .overflow  (overflow1)
  );

  assign w_unused_full = w_full0 | w_full1;

  // Strict alternation: an empty selected lane stalls the output, never skipped.
  always_comb begin
    sel_d       = sel_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    w_pop0      = 1'b0;
    w_pop1      = 1'b0;
    if (sel_q == LANE0) begin
      if (!w_empty0) begin
        w_pop0      = 1'b1;
        data_out_d  = w_head0;
        valid_out_d = 1'b1;
        sel_d       = LANE1;
      end
    end else begin
      if (!w_empty1) begin
        w_pop1      = 1'b1;
        data_out_d  = w_head1;
        valid_out_d = 1'b1;
        sel_d       = LANE0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= LANE0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign expect_lane = sel_q;

endmodule

`default_nettype wire
